// File: rtl/div.sv
// div -- multi-cycle 32-bit restoring divider, signed or unsigned.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = two's-complement divide, 0 = unsigned
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request; held high until the result is consumed
//   annul_i      abort the operation in flight (pipeline flush)
//   result_o     {remainder[63:32], quotient[31:0]}, registered
//   ready_o      result_o valid, registered
//
// Operands are captured (as magnitudes) on the accepting edge. One quotient
// bit is produced per edge, MSB first, and the sign correction is applied
// when the result is registered.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {
      DIV_FREE,
      DIV_BYZERO,
      DIV_ON,
      DIV_END
   } state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] rem;     // partial remainder
   logic [31:0] quo;     // dividend bits shifting out, quotient bits shifting in
   logic [31:0] dvs;     // divisor magnitude
   logic        neg_q;   // negate quotient at the end
   logic        neg_r;   // negate remainder at the end

   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] fixed_q;
   logic [31:0] fixed_r;

   always_comb begin
      abs_a = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
      abs_b = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
      // rem < dvs always holds, so bit 32 of the 33-bit difference is the
      // borrow: set exactly when the divisor does not fit.
      shifted = {rem, quo[31]};
      trial   = shifted - {1'b0, dvs};
      fixed_q = neg_q ? -quo : quo;
      fixed_r = neg_r ? -rem : rem;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DIV_FREE;
         cnt      <= '0;
         ready_o  <= 1'b0;
         result_o <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else begin
         case (state)
            DIV_FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= DIV_BYZERO;
                  end else begin
                     state <= DIV_ON;
                     cnt   <= '0;
                     rem   <= '0;
                     quo   <= abs_a;
                     dvs   <= abs_b;
                     neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                     neg_r <= signed_div_i && opdata1_i[31];
                  end
               end
            end
            DIV_BYZERO: begin
               result_o <= '0;
               if (annul_i) begin
                  state   <= DIV_FREE;
                  ready_o <= 1'b0;
               end else begin
                  state   <= DIV_END;
                  ready_o <= 1'b1;
               end
            end
            DIV_ON: begin
               if (annul_i) begin
                  state    <= DIV_FREE;
                  cnt      <= '0;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else if (cnt == 6'd32) begin
                  state    <= DIV_END;
                  cnt      <= '0;
                  ready_o  <= 1'b1;
                  result_o <= {fixed_r, fixed_q};
               end else begin
                  cnt <= cnt + 6'd1;
                  if (!trial[32]) begin
                     rem <= trial[31:0];
                     quo <= {quo[30:0], 1'b1};
                  end else begin
                     rem <= shifted[31:0];
                     quo <= {quo[30:0], 1'b0};
                  end
               end
            end
            DIV_END: begin
               if (!start_i || annul_i) begin
                  state    <= DIV_FREE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end
            end
            default: begin
               state    <= DIV_FREE;
               cnt      <= '0;
               ready_o  <= 1'b0;
               result_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
module tb_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer division on widened operands.
   function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
      longint la, lb, q, r;
      logic [63:0] qq, rr;
      if (b == '0) return '0;
      if (sg) begin
         la = longint'($signed(a));
         lb = longint'($signed(b));
      end else begin
         la = longint'({32'd0, a});
         lb = longint'({32'd0, b});
      end
      q  = la / lb;
      r  = la % lb;
      qq = 64'(q);
      rr = 64'(r);
      return {rr[31:0], qq[31:0]};
   endfunction

   // Issue one operation with start held; all timing is sampled on negedge,
   // so k negedges after the request means k rising edges have occurred.
   task automatic run_op(input string tag, input bit sg, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble);
      logic [63:0] exp;
      int unsigned k;
      bit          got;
      exp = model(sg, a, b);
      @(negedge clk);
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      k   = 0;
      got = 1'b0;
      while (k < 40 && !got) begin
         @(negedge clk);
         k++;
         if (ready_o) got = 1'b1;
         else if (scramble) begin
            signed_div_i = 1'($urandom);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
         end
      end
      check({tag, " latency"}, 64'(k), (b == '0) ? 64'd2 : 64'd34);
      check({tag, " result"}, result_o, exp);
      repeat (2) begin
         @(negedge clk);
         check({tag, " hold ready"}, 64'(ready_o), 64'd1);
         check({tag, " hold result"}, result_o, exp);
      end
      start_i = 1'b0;
      @(negedge clk);
      check({tag, " release ready"}, 64'(ready_o), 64'd0);
      check({tag, " release result"}, result_o, 64'd0);
   endtask

   // Start an operation and advance until n edges past the accepting edge
   // have occurred, checking that no result appears meanwhile.
   task automatic start_and_wait(input string tag, input int unsigned n);
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd12345678;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      repeat (n + 1) @(negedge clk);
      check({tag, " busy ready"}, 64'(ready_o), 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset ready", 64'(ready_o), 64'd0);
      check("reset result", result_o, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle ready", 64'(ready_o), 64'd0);

      // Directed cases.
      run_op("u100/7", 1'b0, 32'd100, 32'd7, 1'b0);
      check("u100/7 model", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
      run_op("s-7/2", 1'b1, 32'hFFFFFFF9, 32'h2, 1'b1);
      run_op("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op("by0", 1'b0, 32'd55, 32'd0, 1'b0);
      run_op("sby0", 1'b1, 32'h80000000, 32'd0, 1'b1);
      run_op("u/1", 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
      run_op("uneg", 1'b0, 32'hFFFFFFF9, 32'h2, 1'b0);
      run_op("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 1'b0);
      run_op("small/big", 1'b0, 32'd5, 32'hFFFFFFFF, 1'b0);

      // Annul at iteration 10 (cnt == 10 after edge 11), applied for edge 12.
      start_and_wait("annul", 10);
      start_i = 1'b0;
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      check("annul ready", 64'(ready_o), 64'd0);
      check("annul result", result_o, 64'd0);
      repeat (35) @(negedge clk);
      check("annul no late ready", 64'(ready_o), 64'd0);
      run_op("post-annul", 1'b0, 32'hFFFFFFFF, 32'h10, 1'b0);

      // Annul while in DIV_END releases the result.
      @(negedge clk);
      opdata1_i = 32'd9;
      opdata2_i = 32'd4;
      signed_div_i = 1'b0;
      start_i = 1'b1;
      repeat (34) @(negedge clk);
      check("end ready", 64'(ready_o), 64'd1);
      check("end result", result_o, 64'h00000001_00000002);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      check("end annul ready", 64'(ready_o), 64'd0);
      check("end annul result", result_o, 64'd0);

      // Reset at iteration 20.
      start_and_wait("reset", 20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start_i = 1'b0;
      check("midrst ready", 64'(ready_o), 64'd0);
      check("midrst result", result_o, 64'd0);
      repeat (35) @(negedge clk);
      check("midrst no ready", 64'(ready_o), 64'd0);

      // Randomized operations; operands scrambled while in flight.
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         bit sg;
         a  = $urandom;
         b  = $urandom;
         sg = 1'($urandom);
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            3: a = 32'h80000000;
            default: ;
         endcase
         run_op("rand", sg, a, b, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
